alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle unsigned MULTU/DIVU sequencer producing HI/LO for the MIPS core.
//  It borrows the shared 32-bit ALU for add/sub steps and does shifts and carry/compare locally.
//  The parent muxes ALU inputs to this block while alu_own=1 and stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH     32   operand width; the iteration count equals WIDTH
//  ALU_ADD   4'b0000  ALU funct code for ADD
//  ALU_SUB   4'b0001  ALU funct code for SUB
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      one-cycle request; sampled only in IDLE
//  op_div     in   1      0 = MULTU, 1 = DIVU; sampled with start
//  opa        in   WIDTH  multiplicand / dividend; sampled with start
//  opb        in   WIDTH  multiplier / divisor; sampled with start
//  alu_a      out  WIDTH  ALU operand a
//  alu_b      out  WIDTH  ALU operand b
//  alu_funct  out  4      ALU function select
//  alu_out    in   WIDTH  ALU result, combinational same cycle
//  alu_own    out  1      1 = parent routes the ALU to this block
//  busy       out  1      1 while in the MUL or DIV state
//  done       out  1      one-cycle completion pulse
//  div0       out  1      divide-by-zero flag; valid with done, held until the next start
//  hi         out  WIDTH  MULTU: product[63:32]; DIVU: remainder
//  lo         out  WIDTH  MULTU: product[31:0];  DIVU: quotient
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - state=IDLE; hi, lo, count = 0; busy, done, div0, alu_own = 0.
//   - A reset mid-operation aborts and discards all partial results.
//  FSM: IDLE -> MUL | DIV | DONE; MUL/DIV -> DONE after WIDTH iterations; DONE -> IDLE.
//  IDLE
//   - start=1, op_div=0: latch mcand=opa; hi=0, lo=opb; count=WIDTH-1; go to MUL.
//   - start=1, op_div=1, opb!=0: latch dvsr=opb; hi=0, lo=opa; go to DIV.
//   - start=1, op_div=1, opb==0: hi=opa, lo={WIDTH{1'b1}}, div0=1; go straight to DONE.
//  MUL, one iteration per cycle
//   - Drive alu_a=hi, alu_b=mcand, alu_funct=ALU_ADD.
//   - c = (alu_out < hi), unsigned compare.
//   - If lo[0]=1: {hi,lo} <= {c, alu_out, lo} >> 1.
//   - Else:       {hi,lo} <= {1'b0, hi, lo} >> 1.
//  DIV, restoring division, one iteration per cycle
//   - r = {hi, lo[WIDTH-1]} (WIDTH+1 bits).
//   - Drive alu_a=r[WIDTH-1:0], alu_b=dvsr, alu_funct=ALU_SUB.
//   - ge = r[WIDTH] | (r[WIDTH-1:0] >= dvsr).
//   - hi <= ge ? alu_out : r[WIDTH-1:0];  lo <= {lo[WIDTH-2:0], ge}.
//  Iteration count
//   - count decrements each iteration; leave MUL/DIV for DONE when count==0.
//   - Exactly WIDTH iterations are performed.
//  DONE: done=1 for exactly one cycle, then IDLE; hi/lo/div0 hold until the next accepted start.
//  Latency: start sampled at edge 0; done=1 during cycle WIDTH+1 (33 for WIDTH=32); div-by-zero: cycle 1.
//  Output timing
//   - busy and alu_own are registered: 1 exactly in MUL/DIV.
//   - alu_a/alu_b/alu_funct = 0 outside MUL/DIV.
//  Ignored inputs
//   - start while busy or in DONE is ignored; no queueing.
//   - Operand changes after the start cycle have no effect.
//  div0 clears on the next accepted start.
// STRUCTURE
//  Shared header alu_defs.vh, also used by the ALU decoder:
//   - ALU funct localparams (ALU_ADD, ALU_SUB, ...).
//   - FSM state encodings: IDLE=2'd0, MUL=2'd1, DIV=2'd2, DONE=2'd3.
//  Single flat module; no sub-module.
//   - The ALU is NOT instantiated here; the parent owns the ALU and its input mux.
// TESTING (bench contains a real ALU instance wired through the alu_own mux)
//  1. MULTU 7 x 6 -> done at cycle 33; hi=0, lo=42, div0=0; busy high for cycles 1-32.
//  2. MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (carry path).
//  3. DIVU 100 / 7 -> lo=14, hi=2; DIVU 32'hFFFFFFFF / 1 -> lo=32'hFFFFFFFF, hi=0;
//     DIVU 32'h80000000 / 32'hFFFFFFFF -> lo=0, hi=32'h80000000.
//  4. DIVU 5 / 0 -> done at cycle 1, div0=1, hi=5, lo=32'hFFFFFFFF; busy never asserts.
//  5. MULTU 3 x 4, then start=1 with MULTU 9 x 9 at cycle 10 -> ignored; result lo=12, single done pulse.
//  6. rst_n=0 at cycle 15 of DIVU 1000 / 3 -> next cycle: IDLE, hi=lo=0, busy=0;
//     a new MULTU 2 x 2 then gives lo=4.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared ALU funct codes and FSM encodings for the MULTU/DIVU sequencer
package alu_muldiv_seq_pkg;

   localparam int DEF_WIDTH = 32;

   // ALU function selects understood by the core's shared ALU
   localparam logic [3:0] ALU_FUNCT_ADD = 4'b0000;
   localparam logic [3:0] ALU_FUNCT_SUB = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle unsigned MULTU/DIVU sequencer borrowing the shared ALU
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int         WIDTH   = DEF_WIDTH,
   parameter logic [3:0] ALU_ADD = ALU_FUNCT_ADD,
   parameter logic [3:0] ALU_SUB = ALU_FUNCT_SUB
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_funct,
   input  logic [WIDTH-1:0] alu_out,
   output logic             alu_own,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   // holds the multiplicand in MUL and the divisor in DIV
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             div0_q, div0_d;
   logic             busy_q;
   logic             own_q;

   logic             last_iter;
   logic             mul_carry;
   logic [WIDTH:0]   div_r;
   logic             div_ge;

   assign last_iter = (count_q == '0);
   // the ALU add wraps on carry-out, so a result below hi means it carried
   assign mul_carry = (alu_out < hi_q);
   // partial remainder shifted left with the next dividend bit brought in
   assign div_r     = {hi_q, lo_q[WIDTH-1]};
   assign div_ge    = div_r[WIDTH] | (div_r[WIDTH-1:0] >= opnd_q);

   // state register plus registered busy / ALU-ownership flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         own_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == ST_MUL) || (state_d == ST_DIV);
         own_q   <= (state_d == ST_MUL) || (state_d == ST_DIV);
      end
   end

   // next-state: IDLE launches, MUL/DIV run WIDTH iterations, DONE lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (!op_div)          state_d = ST_MUL;
               else if (opb != '0)   state_d = ST_DIV;
               else                  state_d = ST_DONE;
            end
         end
         ST_MUL:  if (last_iter) state_d = ST_DONE;
         ST_DIV:  if (last_iter) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // datapath next values: shift-add multiply, restoring divide
   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      count_d = count_q;
      div0_d  = div0_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d = CW'(WIDTH - 1);
               div0_d  = 1'b0;
               if (!op_div) begin
                  opnd_d = opa;
                  hi_d   = '0;
                  lo_d   = opb;
               end else if (opb != '0) begin
                  opnd_d = opb;
                  hi_d   = '0;
                  lo_d   = opa;
               end else begin
                  hi_d   = opa;
                  lo_d   = '1;
                  div0_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (lo_q[0]) begin
               hi_d = {mul_carry, alu_out[WIDTH-1:1]};
               lo_d = {alu_out[0], lo_q[WIDTH-1:1]};
            end else begin
               hi_d = {1'b0, hi_q[WIDTH-1:1]};
               lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
            end
            count_d = last_iter ? '0 : count_q - 1'b1;
         end
         ST_DIV: begin
            hi_d    = div_ge ? alu_out : div_r[WIDTH-1:0];
            lo_d    = {lo_q[WIDTH-2:0], div_ge};
            count_d = last_iter ? '0 : count_q - 1'b1;
         end
         default: ;
      endcase
   end

   // datapath registers; reset discards any partial result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         count_q <= '0;
         div0_q  <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         count_q <= count_d;
         div0_q  <= div0_d;
      end
   end

   // outputs: ALU operands only while iterating, zero otherwise
   always_comb begin
      alu_a     = '0;
      alu_b     = '0;
      alu_funct = 4'b0000;
      case (state_q)
         ST_MUL: begin
            alu_a     = hi_q;
            alu_b     = opnd_q;
            alu_funct = ALU_ADD;
         end
         ST_DIV: begin
            alu_a     = div_r[WIDTH-1:0];
            alu_b     = opnd_q;
            alu_funct = ALU_SUB;
         end
         default: ;
      endcase
      done    = (state_q == ST_DONE);
      busy    = busy_q;
      alu_own = own_q;
      div0    = div0_q;
      hi      = hi_q;
      lo      = lo_q;
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq with a real ALU behind the ownership mux
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         op_div;
   logic [W-1:0] opa, opb;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic [3:0]   alu_funct;
   logic         alu_own, busy, done, div0;
   logic [W-1:0] hi, lo;

   logic [W-1:0] pipe_a, pipe_b, alu_in_a, alu_in_b;
   logic [3:0]   pipe_funct, alu_in_funct;

   always #5 clk = ~clk;

   alu_muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
      .opa(opa), .opb(opb), .alu_a(alu_a), .alu_b(alu_b),
      .alu_funct(alu_funct), .alu_out(alu_out), .alu_own(alu_own),
      .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
   );

   // parent-side mux and a small shared ALU
   assign alu_in_a     = alu_own ? alu_a : pipe_a;
   assign alu_in_b     = alu_own ? alu_b : pipe_b;
   assign alu_in_funct = alu_own ? alu_funct : pipe_funct;
   always_comb begin
      case (alu_in_funct)
         ALU_FUNCT_ADD: alu_out = alu_in_a + alu_in_b;
         ALU_FUNCT_SUB: alu_out = alu_in_a - alu_in_b;
         default:       alu_out = alu_in_a & alu_in_b;
      endcase
   end

   typedef struct {
      logic         op_div;
      logic [W-1:0] a, b, hi, lo;
      logic         div0;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi, lo;
      logic         div0;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // scoreboard: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         exp_t e;
         n_done++;
         chk("sb_pending_at_done", 64'(sb.size()), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result_hi", 64'(hi), 64'(e.hi));
            chk("result_lo", 64'(lo), 64'(e.lo));
            chk("result_div0", 64'(div0), 64'(e.div0));
         end
      end
   end

   task automatic do_op(input vec_t v, input string tag);
      int lat;
      int bad;
      bit act;
      logic [3:0] fexp;
      @(negedge clk);
      op_div = v.op_div;
      opa    = v.a;
      opb    = v.b;
      start  = 1'b1;
      sb.push_back('{v.hi, v.lo, v.div0});
      @(posedge clk);
      #1;
      start = 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      fexp  = v.op_div ? ALU_FUNCT_SUB : ALU_FUNCT_ADD;
      lat   = -1;
      bad   = 0;
      for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
         @(negedge clk);
         act = (v.lat > 1) && (cyc < v.lat);
         if (busy !== act || alu_own !== act) bad++;
         if (act && alu_funct !== fexp) bad++;
         if (!act && (alu_a !== '0 || alu_b !== '0 || alu_funct !== 4'b0000)) bad++;
         if (done === 1'b1) lat = cyc;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
      chk({tag, "_busy_window"}, 64'(bad), 64'd0);
      @(negedge clk);
      chk({tag, "_done_single_cycle"}, 64'(done), 64'd0);
   endtask

   vec_t vecs[9];

   initial begin
      vec_t v;
      int   lat;
      int   d0;
      logic [63:0] prod;

      vecs[0] = '{1'b0, 32'd7,         32'd6,         32'd0,         32'd42,        1'b0, 33};
      vecs[1] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h00000001,  1'b0, 33};
      vecs[2] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
      vecs[3] = '{1'b1, 32'hFFFFFFFF,  32'd1,         32'd0,         32'hFFFFFFFF,  1'b0, 33};
      vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 33};
      vecs[5] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1'b1, 1};
      vecs[6] = '{1'b0, 32'd0,         32'h12345678,  32'd0,         32'd0,         1'b0, 33};
      vecs[7] = '{1'b1, 32'd7,         32'd9,         32'd7,         32'd0,         1'b0, 33};
      vecs[8] = '{1'b0, 32'h00010000,  32'h00010000,  32'd1,         32'd0,         1'b0, 33};

      rst_n      = 1'b0;
      start      = 1'b0;
      op_div     = 1'b0;
      opa        = '0;
      opb        = '0;
      pipe_a     = 32'h1234;
      pipe_b     = 32'h5678;
      pipe_funct = ALU_FUNCT_ADD;
      repeat (3) @(negedge clk);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_div0", 64'(div0), 64'd0);
      chk("reset_alu_own", 64'(alu_own), 64'd0);
      chk("reset_alu_ab", {alu_a, alu_b}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

      // randomized operands against a reference model
      for (int i = 0; i < 6; i++) begin
         v.op_div = i[0];
         v.a      = $urandom;
         v.b      = (i[0] && i[1]) ? ($urandom >> $urandom_range(31, 1)) | 32'd1 : $urandom;
         if (v.b == '0) v.b = 32'd3;
         if (v.op_div) begin
            v.hi = v.a % v.b;
            v.lo = v.a / v.b;
         end else begin
            prod = {32'd0, v.a} * {32'd0, v.b};
            v.hi = prod[63:32];
            v.lo = prod[31:0];
         end
         v.div0 = 1'b0;
         v.lat  = 33;
         do_op(v, $sformatf("rand%0d", i));
      end

      // start while busy and while in DONE must both be ignored
      sb.push_back('{32'd0, 32'd12, 1'b0});
      d0 = n_done;
      @(negedge clk);
      op_div = 1'b0;
      opa    = 32'd3;
      opb    = 32'd4;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(negedge clk);
         if (done === 1'b1 && lat < 0) lat = cyc;
         if (cyc == 9 || cyc == 33) begin
            start = 1'b1;
            opa   = 32'd9;
            opb   = 32'd9;
         end
         if (cyc == 10 || cyc == 34) start = 1'b0;
      end
      chk("ignore_start_latency", 64'(lat), 64'd33);
      chk("ignore_start_done_count", 64'(n_done - d0), 64'd1);

      // reset in the middle of a divide discards everything
      @(negedge clk);
      op_div = 1'b1;
      opa    = 32'd1000;
      opb    = 32'd3;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk("abort_busy_before_reset", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_alu_own", 64'(alu_own), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      v = '{1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 33};
      do_op(v, "after_abort");

      repeat (2) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
